// File: rtl/ss_pkg.sv
// Shared types and constants for the dual-lane data-memory sequencing arbiter.
// Optional store-to-load bypass is controlled by SS_ST_LD_BYPASS_EN (see ss_dmem_arbiter).
package ss_pkg;

  // Widths of the captured slot record; the arbiter defaults its AW/DW to these.
  localparam int SS_AW    = 32;
  localparam int SS_DW    = 32;
  // Byte-offset bits inside a memory word.
  localparam int WORD_OFS = 2;

  typedef enum logic [1:0] {
    IDLE,
    SERV1,
    SERV2,
    DONE
  } state_e;

  // One lane's captured memory request.
  typedef struct packed {
    logic             req;
    logic             we;
    logic [SS_AW-1:0] addr;
    logic [SS_DW-1:0] wdata;
  } slot_t;

  // Clear the byte-offset bits so the memory only ever sees word addresses.
  function automatic logic [SS_AW-1:0] word_align(input logic [SS_AW-1:0] a);
    return a & ~SS_AW'((1 << WORD_OFS) - 1);
  endfunction

endpackage

// File: rtl/ss_dmem_slot.sv
// Per-lane capture register: holds one lane's request for the duration of a bundle.
module ss_dmem_slot
  import ss_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load_i,
  input  logic  clear_i,
  input  slot_t d_i,
  output slot_t q_o
);

  slot_t slot_q;

  // Capture the lane request on load; clear at end of bundle or on reset.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset || clear_i) begin
      slot_q <= '0;
    end else if (load_i) begin
      slot_q <= d_i;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/ss_dmem_arbiter.sv
// Shares one data-memory port between the two M-stage lanes. A bundle is
// captured in IDLE, lane 1 is served before lane 2, and the pipeline is
// stalled until both complete. Define SS_ST_LD_BYPASS_EN to let a lane-2 load
// take its data from a same-word lane-1 store instead of a second access.
module ss_dmem_arbiter
  import ss_pkg::*;
#(
  parameter int AW = SS_AW,
  parameter int DW = SS_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req1,
  input  logic          req2,
  input  logic          we1,
  input  logic          we2,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic          done1,
  output logic          done2,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  state_e        state_q;
  slot_t         s1_d, s2_d, s1_q, s2_q;
  logic          capture, release_slots, bypass;
  logic [DW-1:0] rdata1_q, rdata2_q;
  logic          done1_q, done2_q;

  // Slots store word-aligned addresses so comparisons and mem_addr ignore bits [1:0].
  assign s1_d = '{req: req1, we: we1, addr: word_align(SS_AW'(addr1)), wdata: SS_DW'(wdata1)};
  assign s2_d = '{req: req2, we: we2, addr: word_align(SS_AW'(addr2)), wdata: SS_DW'(wdata2)};

  assign capture       = (state_q == IDLE) && (req1 || req2);
  assign release_slots = (state_q == DONE);

  ss_dmem_slot u_slot1 (
    .clk    (clk),
    .reset  (reset),
    .load_i (capture),
    .clear_i(release_slots),
    .d_i    (s1_d),
    .q_o    (s1_q)
  );

  ss_dmem_slot u_slot2 (
    .clk    (clk),
    .reset  (reset),
    .load_i (capture),
    .clear_i(release_slots),
    .d_i    (s2_d),
    .q_o    (s2_q)
  );

`ifdef SS_ST_LD_BYPASS_EN
  // Lane-2 load of the word lane 1 just stored: the store data is the answer.
  assign bypass = s1_q.req && s1_q.we && s2_q.req && !s2_q.we && (s1_q.addr == s2_q.addr);
`else
  assign bypass = 1'b0;
`endif

  // Sequencer: state, per-lane load data and one-cycle completion pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      rdata1_q <= '0;
      rdata2_q <= '0;
      done1_q  <= 1'b0;
      done2_q  <= 1'b0;
    end else begin
      done1_q <= 1'b0;
      done2_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req1 || req2) state_q <= req1 ? SERV1 : SERV2;
        end
        SERV1: begin
          if (mem_ack) begin
            if (!s1_q.we) rdata1_q <= mem_rdata;
            if (bypass) begin
              rdata2_q <= DW'(s1_q.wdata);
              state_q  <= DONE;
              done1_q  <= 1'b1;
              done2_q  <= 1'b1;
            end else if (s2_q.req) begin
              state_q <= SERV2;
            end else begin
              state_q <= DONE;
              done1_q <= 1'b1;
            end
          end
        end
        SERV2: begin
          if (mem_ack) begin
            if (!s2_q.we) rdata2_q <= mem_rdata;
            state_q <= DONE;
            done1_q <= s1_q.req;
            done2_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory port driven from the slot being served; quiet in IDLE and DONE.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == SERV1) begin
      mem_req   = 1'b1;
      mem_we    = s1_q.we;
      mem_addr  = AW'(s1_q.addr);
      mem_wdata = DW'(s1_q.wdata);
    end else if (state_q == SERV2) begin
      mem_req   = 1'b1;
      mem_we    = s2_q.we;
      mem_addr  = AW'(s2_q.addr);
      mem_wdata = DW'(s2_q.wdata);
    end
  end

  // Stall is combinational so the issuing bundle freezes in its own cycle.
  assign stall = (state_q == SERV1) || (state_q == SERV2) ||
                 ((state_q == IDLE) && (req1 || req2));

  assign rdata1 = rdata1_q;
  assign rdata2 = rdata2_q;
  assign done1  = done1_q;
  assign done2  = done2_q;

endmodule

// File: tb/tb_ss_dmem_arbiter.sv
// Self-checking bench for ss_dmem_arbiter: a bench-owned memory responder and
// two scoreboard queues (expected memory accesses, expected bundle results).
module tb_ss_dmem_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct packed {
    logic        done1;
    logic        done2;
    logic [31:0] rd1;
    logic [31:0] rd2;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req1, req2, we1, we2;
  logic [31:0] addr1, addr2, wdata1, wdata2;
  logic [31:0] rdata1, rdata2;
  logic        done1, done2, stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          lat          = 1;
  int          wait_cnt     = 0;
  bit          spur_ack     = 1'b0;
  logic [31:0] exp_rd1      = 32'h0;
  logic [31:0] exp_rd2      = 32'h0;

  acc_t        acc_q[$];
  res_t        res_q[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  always #5 clk = ~clk;

  ss_dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .req1     (req1),
    .req2     (req2),
    .we1      (we1),
    .we2      (we2),
    .addr1    (addr1),
    .addr2    (addr2),
    .wdata1   (wdata1),
    .wdata2   (wdata2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .done1    (done1),
    .done2    (done2),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  function automatic logic [31:0] dflt(input logic [31:0] w);
    return w ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
  endfunction

  // Memory responder: acks after `lat` request cycles, checks each access
  // against the expected-access queue.
  initial begin
    acc_t e;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (wait_cnt >= lat - 1) begin
          wait_cnt  = 0;
          mem_ack   = 1'b1;
          mem_rdata = mem_we ? 32'h0 : (mem.exists(mem_addr) ? mem[mem_addr] : dflt(mem_addr));
          if (mem_we) mem[mem_addr] = mem_wdata;
          tests_run++;
          if (acc_q.size() == 0) begin
            tests_failed++;
            $display("FAIL mem_access: unexpected access we=%0b addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);
          end else begin
            e = acc_q.pop_front();
            if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
              tests_failed++;
              $display("FAIL mem_access: got we=%0b addr=%h wdata=%h, expected we=%0b addr=%h wdata=%h",
                       mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
            end
          end
        end else begin
          mem_ack  = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        wait_cnt  = 0;
        mem_ack   = spur_ack;
        mem_rdata = spur_ack ? 32'hBADC_0FFE : 32'h0;
      end
    end
  end

  // Drive one bundle, wait for its done pulse, check results and stall length,
  // then confirm requests held through DONE did not start another access.
  task automatic run_bundle(input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                            input bit r2, input bit w2, input logic [31:0] a2, input logic [31:0] d2,
                            input int l, input int exp_stall, input string name);
    res_t        r;
    bit          byp;
    bit          seen;
    int          scnt;
    logic [31:0] w1a, w2a;
    w1a = {a1[31:2], 2'b00};
    w2a = {a2[31:2], 2'b00};
    byp = 1'b0;
`ifdef SS_ST_LD_BYPASS_EN
    byp = r1 && w1 && r2 && !w2 && (w1a == w2a);
`endif
    if (r1) begin
      acc_q.push_back(acc_t'{we: w1, addr: w1a, wdata: d1});
      if (w1) ref_mem[w1a] = d1;
      else    exp_rd1 = rd_ref(w1a);
    end
    if (r2) begin
      if (!byp) acc_q.push_back(acc_t'{we: w2, addr: w2a, wdata: d2});
      if (w2) ref_mem[w2a] = d2;
      else    exp_rd2 = byp ? d1 : rd_ref(w2a);
    end
    res_q.push_back(res_t'{done1: r1, done2: r2, rd1: exp_rd1, rd2: exp_rd2});

    @(negedge clk);
    lat = l;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    req2 = r2; we2 = w2; addr2 = a2; wdata2 = d2;
    #1;
    scnt = stall ? 1 : 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done1 || done2) seen = 1'b1;
      else if (stall)     scnt++;
    end

    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s_timeout: no done pulse in 200 cycles", name);
      res_q.delete();
      acc_q.delete();
    end else begin
      r = res_q.pop_front();
      tests_run++;
      if ({done1, done2} !== {r.done1, r.done2}) begin
        tests_failed++;
        $display("FAIL %s_done: got %b expected %b", name, {done1, done2}, {r.done1, r.done2});
      end
      tests_run++;
      if (rdata1 !== r.rd1) begin
        tests_failed++;
        $display("FAIL %s_rdata1: got %h expected %h", name, rdata1, r.rd1);
      end
      tests_run++;
      if (rdata2 !== r.rd2) begin
        tests_failed++;
        $display("FAIL %s_rdata2: got %h expected %h", name, rdata2, r.rd2);
      end
      tests_run++;
      if (stall !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_stall_in_done: got %b expected 0", name, stall);
      end
      tests_run++;
      if (scnt != exp_stall) begin
        tests_failed++;
        $display("FAIL %s_stall_cycles: got %0d expected %0d", name, scnt, exp_stall);
      end
    end

    // Requests stayed high through DONE; drop them in the following IDLE cycle.
    @(posedge clk);
    #1;
    req1 = 1'b0; req2 = 1'b0; we1 = 1'b0; we2 = 1'b0;
    #1;
    tests_run++;
    if ({done1, done2, stall, mem_req} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL %s_after_done: got done/stall/mem_req=%b expected 0000", name, {done1, done2, stall, mem_req});
    end
    tests_run++;
    if (acc_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_accesses: got %0d missing accesses expected 0", name, acc_q.size());
      acc_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req1 = 1'b0; req2 = 1'b0; we1 = 1'b0; we2 = 1'b0;
    addr1 = 32'h0; addr2 = 32'h0; wdata1 = 32'h0; wdata2 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({stall, done1, done2, mem_req, mem_we} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got stall/done1/done2/mem_req/mem_we=%b expected 00000",
               {stall, done1, done2, mem_req, mem_we});
    end
    tests_run++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got %h/%h expected 0/0", rdata1, rdata2);
    end
    tests_run++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0/0", mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_load();
    mem[32'h100]     = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    run_bundle(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2, 3, "single_load");
  endtask

  task automatic test_lane2_store();
    run_bundle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h204, 32'h55, 1, 2, "lane2_store");
  endtask

  task automatic test_same_word_stores();
    run_bundle(1'b1, 1'b1, 32'h40, 32'h11, 1'b1, 1'b1, 32'h40, 32'h22, 1, 3, "same_word_stores");
    tests_run++;
    if (mem[32'h40] !== 32'h22) begin
      tests_failed++;
      $display("FAIL same_word_final: got %h expected 00000022", mem[32'h40]);
    end
  endtask

  task automatic test_store_load();
`ifdef SS_ST_LD_BYPASS_EN
    run_bundle(1'b1, 1'b1, 32'h80, 32'hA5, 1'b1, 1'b0, 32'h83, 32'h0, 1, 2, "store_load_bypass");
`else
    run_bundle(1'b1, 1'b1, 32'h80, 32'hA5, 1'b1, 1'b0, 32'h83, 32'h0, 1, 3, "store_load_ordered");
`endif
  endtask

  task automatic test_back_to_back();
    run_bundle(1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 1'b0, 32'h306, 32'h0, 3, 7, "b2b_dual_load");
    run_bundle(1'b1, 1'b0, 32'h41, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1, 2, "b2b_single");
  endtask

  task automatic test_reset_mid();
    bit found;
    @(negedge clk);
    acc_q.push_back(acc_t'{we: 1'b0, addr: 32'h500, wdata: 32'h0});
    lat = 5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h500;
    req2 = 1'b1; we2 = 1'b0; addr2 = 32'h504;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      #1;
      if (mem_req && mem_addr == 32'h504) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL reset_mid_reach: lane 2 access not seen within 50 cycles");
    end
    @(negedge clk);
    reset = 1'b0;
    req1 = 1'b0; req2 = 1'b0;
    @(posedge clk);
    #1;
    acc_q.delete();
    exp_rd1 = 32'h0;
    exp_rd2 = 32'h0;
    tests_run++;
    if ({mem_req, stall, done1, done2} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_mid_ctrl: got mem_req/stall/done1/done2=%b expected 0000", {mem_req, stall, done1, done2});
    end
    tests_run++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_rdata: got %h/%h expected 0/0", rdata1, rdata2);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({mem_req, stall, done1, done2} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_mid_release: got mem_req/stall/done1/done2=%b expected 0000", {mem_req, stall, done1, done2});
    end
  endtask

  task automatic test_spurious_ack();
    @(negedge clk);
    spur_ack = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({mem_req, stall, done1, done2} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL spurious_ack_ctrl: got mem_req/stall/done1/done2=%b expected 0000", {mem_req, stall, done1, done2});
    end
    tests_run++;
    if (rdata1 !== exp_rd1 || rdata2 !== exp_rd2) begin
      tests_failed++;
      $display("FAIL spurious_ack_rdata: got %h/%h expected %h/%h", rdata1, rdata2, exp_rd1, exp_rd2);
    end
    @(negedge clk);
    spur_ack = 1'b0;
    run_bundle(1'b1, 1'b0, 32'h102, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1, 2, "after_spurious");
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_lane2_store();
    test_same_word_stores();
    test_store_load();
    test_back_to_back();
    test_reset_mid();
    test_spurious_ack();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ss_dmem_arbiter.md
# ss_dmem_arbiter

Sequencing arbiter that shares the single data-memory port between the two M-stage lanes of the dual-issue pipeline. It captures both lanes' load/store requests from one bundle, serves them strictly in program order (lane 1 before lane 2), and holds the global pipeline stall until both are complete. It sits between the two datapath M stages, the hazard unit (stall), and the memory controller (req/ack handshake).

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  active-low synchronous reset (one clock; reset is synchronous and active-low)
- req1, req2  in  1  lane M-stage memory access request
- we1, we2  in  1  1 = store, 0 = load
- addr1, addr2  in  AW  byte address; bits [1:0] ignored
- wdata1, wdata2  in  DW  store data
- rdata1, rdata2  out  DW  registered load data per lane
- done1, done2  out  1  one-cycle pulse, lane access completed
- stall  out  1  freeze all pipeline registers, both lanes
- mem_req  out  1  request to memory controller
- mem_we  out  1  write enable to memory
- mem_addr  out  AW  word-aligned address {addr[AW-1:2],2'b00}
- mem_wdata  out  DW  store data to memory
- mem_rdata  in  DW  load data, valid when mem_ack=1
- mem_ack  in  1  access complete, one-cycle pulse

## Operation
- States: IDLE, SERV1, SERV2, DONE.
- IDLE: if req1|req2, latch {req,we,addr,wdata} of both lanes into slot registers; go SERV1 if req1, else SERV2. No request: stay.
- SERV1: mem_req=1 with slot 1 fields. On mem_ack: capture mem_rdata into rdata1 if load; go SERV2 if slot 2 pending, else DONE.
- SERV2: same for slot 2; on mem_ack go DONE.
- DONE: stall=0; done1/done2 pulse for each lane served; inputs ignored (lane reqs still reflect the just-served bundle); next state IDLE.
- stall = (state != IDLE && state != DONE) | (state == IDLE & (req1|req2)); combinational so the bundle freezes in its issue cycle.
- mem_req, mem_we, mem_addr, mem_wdata driven combinationally from state + slot registers; all zero outside SERV1/SERV2.
- mem_req stays high until mem_ack; mem_ack outside SERV1/SERV2 ignored.
- Two stores to same word: both issued, lane 1 first; memory ends with wdata2.
- Reset values: state IDLE; rdata1=rdata2=0; done1=done2=0; stall=0 (when reqs low); mem_* = 0; slots cleared.
- Reset mid-access: state returns to IDLE next edge; mem_req drops; captured data discarded; memory controller must tolerate abandoned request.

## Timing
- Single load, memory ack latency L cycles after mem_req rises: cycle 0 IDLE (stall=1), cycles 1..L SERV1, cycle L+1 DONE (done1=1, rdata1 valid, stall=0). Total stall = L+1 cycles.
- Dual access: stall = L1 + L2 + 1 cycles; done1 and done2 pulse together in DONE.
- rdata holds until overwritten by a later load on that lane.
- Back-to-back bundles: new request accepted in IDLE the cycle after DONE; minimum one unstalled cycle between memory bundles.

## Configuration
- SS_ST_LD_BYPASS_EN defined: when slot 1 is a store, slot 2 a load, and addr1[AW-1:2]==addr2[AW-1:2], SERV2 is skipped; rdata2 = wdata1 captured on leaving SERV1, which goes directly to DONE. Saves L2 cycles.
- Undefined: slot 2 always issued to memory after slot 1; correctness preserved by ordering.

## Structure
- Shared package ss_pkg: state enum (IDLE/SERV1/SERV2/DONE), word-offset constant (2), slot record typedef {req,we,addr,wdata}.
- One sub-module: ss_dmem_slot, per-lane capture register with load/clear, instantiated twice.

## Test plan
- Lane 1 load 0x100, mem_ack 2 cycles after mem_req, mem_rdata=0xDEADBEEF -> stall high 3 cycles, done1 pulse, rdata1=0xDEADBEEF, done2=0.
- Lane 2 store only, addr 0x204, wdata 0x55 -> state skips SERV1; mem_we=1, mem_addr=0x204; done2 only.
- Both lanes store 0x40 (0x11 then 0x22), ack latency 1 -> two mem_req phases in order, memory word 0x40 = 0x22, stall 3 cycles.
- Lane 1 store 0x80=0xA5, lane 2 load 0x83 -> with SS_ST_LD_BYPASS_EN one memory access, rdata2=0xA5, stall 2 cycles (L=1); without macro two accesses, rdata2=0xA5 from memory.
- Reset asserted low during SERV2 -> next edge state IDLE, mem_req=0, stall=0, no done pulse, rdata unchanged to 0.
- Spurious mem_ack in IDLE, and reqs held during DONE -> no state change, no extra access.
